// File: rtl/led_event_blinker_if.sv
// Event request / LED status bundle between core logic and the blinker.
interface led_event_blinker_if;
    logic i_Event;
    logic o_LED;
    logic o_Busy;
    logic o_Overflow;

    // Event source side: raises requests, observes LED status.
    modport master (
        output i_Event,
        input  o_LED,
        input  o_Busy,
        input  o_Overflow
    );

    // Blinker side.
    modport slave (
        input  i_Event,
        output o_LED,
        output o_Busy,
        output o_Overflow
    );
endinterface

// File: rtl/led_event_blinker.sv
// Turns single-cycle events into human-visible LED blinks: each request
// queues one blink of c_ON_TIME cycles on, followed by c_OFF_TIME cycles off.
module led_event_blinker #(
    parameter int unsigned c_ON_TIME     = 2500000,
    parameter int unsigned c_OFF_TIME    = 2500000,
    parameter int unsigned c_TIMER_WIDTH = 22,
    parameter int unsigned c_PEND_WIDTH  = 4
) (
    input  logic                 clock,
    input  logic                 i_Reset_n,
    led_event_blinker_if.slave   bus
);

    localparam int unsigned TW = c_TIMER_WIDTH;
    localparam int unsigned PW = c_PEND_WIDTH;

    localparam logic [TW-1:0] ON_LAST  = TW'(c_ON_TIME - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(c_OFF_TIME - 1);
    localparam logic [PW-1:0] PEND_MAX = {PW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic          consume;

    // Next-state, timer, pending-queue and output decode.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        consume   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Only requests already counted start a blink; no same-edge bypass.
                if (pending_q != '0) begin
                    state_d = ST_ON;
                    timer_d = '0;
                    consume = 1'b1;
                end
            end
            ST_ON: begin
                if (timer_q == ON_LAST) begin
                    state_d = ST_OFF;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_OFF: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    // Chain straight into the next blink when one is queued.
                    if (pending_q != '0) begin
                        state_d = ST_ON;
                        consume = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Saturating request counter; a request at full depth is dropped and flagged.
        if (bus.i_Event && !consume) begin
            if (pending_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = pending_q + PW'(1);
            end
        end else if (!bus.i_Event && consume) begin
            pending_d = pending_q - PW'(1);
        end

        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE) || (pending_d != '0);
    end

    // State and registered outputs; reset discards any blink in progress.
    always_ff @(posedge clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pending_q <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.o_LED      = led_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_Overflow = ovf_q;

endmodule
